// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer type and binary/Gray conversions for the dual-clock FIFO
package fifo_pkg;
  localparam int PTR_MAX_W = 16;
  typedef logic [PTR_MAX_W-1:0] ptr_t;
  function automatic ptr_t width_mask(input int unsigned w);
    return (ptr_t'(1) << w) - ptr_t'(1);
  endfunction
  function automatic ptr_t bin2gray(input ptr_t b, input int unsigned w);
    return (b ^ (b >> 1)) & width_mask(w);
  endfunction
  function automatic ptr_t gray2bin(input ptr_t g, input int unsigned w);
    ptr_t b;
    b = g & width_mask(w);
    for (int i = 1; i < PTR_MAX_W; i++) b = b ^ ((g & width_mask(w)) >> i);
    return b;
  endfunction
endpackage

// File: rtl/sync_vec.sv
// sync_vec: STAGES-deep flop chain carrying a W-bit vector into the clk domain
module sync_vec #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [STAGES*W-1:0] chain_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) chain_q <= '0;
    else     chain_q <= {chain_q[(STAGES-1)*W-1:0], d_i};
  assign q_o = chain_q[STAGES*W-1 -: W];
endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl: write-domain pointer, full/level/overflow control of the dual-clock FIFO
module async_fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_THR   = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_valid,
  output logic            push_ready,
  output logic            mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W:0] wptr_gray,
  input  logic [ADDR_W:0] rptr_gray_in,
  output logic            full,
  output logic            almost_full,
  output logic [ADDR_W:0] level,
  output logic            overflow,
  input  logic            clr_overflow
);
  localparam int PW = ADDR_W + 1;
  logic [ADDR_W:0] bin_q, bin_d, gray_q, gray_d, level_q, level_d, rq, rq_bin, full_pat;
  logic full_q, afull_q, ovf_q, ovf_d, push;
  sync_vec #(.W(PW), .STAGES(SYNC_STAGES)) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rptr_gray_in),
    .q_o (rq)
  );
  assign push        = push_valid & ~full_q;
  assign push_ready  = ~full_q;
  assign mem_we      = push;
  assign mem_waddr   = bin_q[ADDR_W-1:0];
  assign wptr_gray   = gray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign level       = level_q;
  assign overflow    = ovf_q;
  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  always_comb begin
    bin_d    = bin_q + PW'(push);
    gray_d   = PW'(bin2gray(ptr_t'(bin_d), PW));
    rq_bin   = PW'(gray2bin(ptr_t'(rq), PW));
    level_d  = bin_d - rq_bin;
    full_pat = rq ^ (PW'(3) << (ADDR_W - 1));
    ovf_d    = (push_valid & full_q) | (ovf_q & ~clr_overflow);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bin_q   <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= (gray_d == full_pat);
      afull_q <= (level_d >= PW'(AFULL_THR));
      ovf_q   <= ovf_d;
    end
endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb_async_fifo_wr_ctrl: randomized bench against a push/read-count occupancy model
module tb_async_fifo_wr_ctrl;
  localparam int AW = 3, DEPTH = 8, THR = 6;
  logic clk = 0, rst = 1, push_valid = 0, clr_overflow = 0;
  logic [AW:0] rptr_gray_in = '0;
  logic push_ready, mem_we, full, almost_full, overflow;
  logic [AW-1:0] mem_waddr;
  logic [AW:0] wptr_gray, level;
  int n_chk = 0, n_fail = 0;
  int wcnt, rcnt, m_level;
  int seen_q[$];
  bit m_full, m_afull, m_ovf;

  async_fifo_wr_ctrl #(.ADDR_W(AW), .SYNC_STAGES(2), .AFULL_THR(THR)) dut (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .wptr_gray    (wptr_gray),
    .rptr_gray_in (rptr_gray_in),
    .full         (full),
    .almost_full  (almost_full),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [AW:0] gray(input int c);
    logic [AW:0] b;
    b = c[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset;
    wcnt = 0; rcnt = 0; m_level = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
    seen_q = '{0, 0};
  endtask

  // The DUT's registered flags at edge n see the read count sampled at edge n-2.
  task automatic step(input bit pv, input bit clr);
    bit acc;
    int seen;
    push_valid = pv; clr_overflow = clr; rptr_gray_in = gray(rcnt);
    #1;
    acc = pv && !m_full;
    chk("push_ready", push_ready, !m_full);
    chk("mem_we", mem_we, acc);
    if (acc) chk("mem_waddr", mem_waddr, wcnt % DEPTH);
    @(posedge clk);
    m_ovf = (pv && m_full) || (m_ovf && !clr);
    wcnt += acc;
    seen_q.push_back(rcnt);
    seen = seen_q.pop_front();
    m_level = wcnt - seen;
    m_full = (m_level == DEPTH);
    m_afull = (m_level >= THR);
    #1;
    chk("wptr_gray", wptr_gray, gray(wcnt));
    chk("full", full, m_full);
    chk("level", level, m_level);
    chk("almost_full", almost_full, m_afull);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_ready"}, push_ready, 1);
    chk({tag, "_waddr"}, mem_waddr, 0);
    chk({tag, "_gray"}, wptr_gray, 0);
  endtask

  initial begin
    int pushes, start_w;
    bit saw_full;
    model_reset();
    push_valid = 1;
    #2 chk_reset_vals("rst_hold");
    @(posedge clk); #1;
    chk_reset_vals("rst_edge");
    rst = 0;
    for (int i = 0; i < 8; i++) step(1, 0);
    chk("t2_full", full, 1);
    chk("t2_gray", wptr_gray, 12);
    for (int i = 0; i < 3; i++) step(1, 0);
    chk("t3_ovf", overflow, 1);
    step(0, 1);
    chk("t3_clr", overflow, 0);
    step(1, 0);
    step(1, 1);
    chk("t3_setwins", overflow, 1);
    step(0, 1);
    rcnt = 1;
    step(0, 0);
    step(0, 0);
    chk("t4_full_lag", full, 1);
    step(0, 0);
    chk("t4_full_drop", full, 0);
    chk("t4_level", level, 7);
    step(1, 0);
    chk("t4_gray", wptr_gray, 13);
    chk("t4_refull", full, 1);
    while (rcnt < wcnt) begin rcnt++; step(0, 0); end
    for (int i = 0; i < 3; i++) step(0, 0);
    chk("drain_level", level, 0);
    pushes = 0; start_w = wcnt; saw_full = 0;
    for (int c = 0; c < 400 && pushes < 20; c++) begin
      if (rcnt < wcnt && $urandom % 2 == 1) rcnt++;
      step((wcnt - rcnt < 4) && ($urandom % 4 != 0), 0);
      saw_full |= full;
      pushes = wcnt - start_w;
    end
    chk("t5_pushes", pushes, 20);
    chk("t5_never_full", saw_full, 0);
    for (int c = 0; c < 300; c++) begin
      if (rcnt < wcnt && $urandom % 3 == 0) rcnt++;
      step($urandom % 4 != 0, $urandom % 8 == 0);
    end
    for (int i = 0; i < 3; i++) step(1, 0);
    rst = 1;
    #2 chk_reset_vals("t6_async");
    rcnt = 0; rptr_gray_in = '0;
    rst = 0;
    model_reset();
    step(1, 0);
    chk("t6_gray", wptr_gray, 1);
    for (int i = 0; i < 5; i++) step(1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
